// File: rtl/secure_op_arbiter.sv
// Round-robin arbiter granting a shared sequencing engine to secure requesters.
// Non-secure requests are rejected with an err pulse without starting the engine.
module secure_op_arbiter #(
    parameter int unsigned N_REQ   = 4,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic [N_REQ-1:0] req_secure,
    output logic [N_REQ-1:0] gnt,
    output logic [N_REQ-1:0] ack,
    output logic [N_REQ-1:0] err,
    output logic             eng_start,
    output logic             eng_secure,
    input  logic             eng_done,
    output logic             busy,
    output logic             spurious
);

    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               secure_q, secure_d;
    logic               ok_q, ok_d;
    logic               spurious_q, spurious_d;

    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   err_q, err_d;
    logic               eng_start_q, eng_start_d;
    logic               eng_secure_q, eng_secure_d;
    logic               busy_q, busy_d;

    logic               found;
    int unsigned        idx;
    logic [IDX_W-1:0]   idx_w;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            winner_q   <= '0;
            rr_ptr_q   <= '0;
            cnt_q      <= '0;
            secure_q   <= 1'b0;
            ok_q       <= 1'b0;
            spurious_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            winner_q   <= winner_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            secure_q   <= secure_d;
            ok_q       <= ok_d;
            spurious_q <= spurious_d;
        end
    end

    // Next-state: round-robin pick in IDLE, engine handshake and timeout in WAIT
    always_comb begin
        state_d    = state_q;
        winner_d   = winner_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        secure_d   = secure_q;
        ok_d       = ok_q;
        spurious_d = spurious_q | (eng_done && (state_q != WAIT));
        found      = 1'b0;
        idx        = 0;
        idx_w      = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned i = 0; i < N_REQ; i++) begin
                    idx   = (32'(rr_ptr_q) + i) % N_REQ;
                    idx_w = IDX_W'(idx);
                    if (!found && req[idx_w]) begin
                        found    = 1'b1;
                        winner_d = idx_w;
                        secure_d = req_secure[idx_w];
                    end
                end
                if (found) begin
                    ok_d    = 1'b0;
                    state_d = secure_d ? ISSUE : RESP;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    ok_d    = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    ok_d    = 1'b0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                rr_ptr_d = (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + IDX_W'(1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output comes straight from a flop
    always_comb begin
        gnt_d        = '0;
        ack_d        = '0;
        err_d        = '0;
        eng_start_d  = 1'b0;
        eng_secure_d = 1'b0;
        busy_d       = 1'b0;
        if (state_d != IDLE) begin
            gnt_d[winner_d] = 1'b1;
            busy_d          = 1'b1;
        end
        if (state_d == ISSUE) begin
            eng_start_d  = 1'b1;
            eng_secure_d = secure_d;
        end
        if (state_d == RESP) begin
            if (ok_d) ack_d[winner_d] = 1'b1;
            else      err_d[winner_d] = 1'b1;
        end
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gnt_q        <= '0;
            ack_q        <= '0;
            err_q        <= '0;
            eng_start_q  <= 1'b0;
            eng_secure_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            gnt_q        <= gnt_d;
            ack_q        <= ack_d;
            err_q        <= err_d;
            eng_start_q  <= eng_start_d;
            eng_secure_q <= eng_secure_d;
            busy_q       <= busy_d;
        end
    end

    assign gnt        = gnt_q;
    assign ack        = ack_q;
    assign err        = err_q;
    assign eng_start  = eng_start_q;
    assign eng_secure = eng_secure_q;
    assign busy       = busy_q;
    assign spurious   = spurious_q;

endmodule

// File: tb/tb_secure_op_arbiter.sv
// Directed bench for secure_op_arbiter: stimulus pushes expected responses,
// a monitor pops and compares each ack/err pulse including its cycle.
module tb_secure_op_arbiter;

    localparam int unsigned N = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] req, req_secure, gnt, ack, err;
    logic         eng_start, eng_secure, eng_done, busy, spurious;
    logic         done_m = 1'b0;
    logic         done_f = 1'b0;

    int cyc       = 0;
    int eng_delay = -1;
    int done_at   = -1;
    int starts    = 0;
    int n_vec     = 0;
    int n_fail    = 0;

    typedef struct {
        logic is_err;
        int   idx;
        int   at;
    } exp_t;
    exp_t exp_q[$];

    secure_op_arbiter #(.N_REQ(N), .TIMEOUT(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .req_secure (req_secure),
        .gnt        (gnt),
        .ack        (ack),
        .err        (err),
        .eng_start  (eng_start),
        .eng_secure (eng_secure),
        .eng_done   (eng_done),
        .busy       (busy),
        .spurious   (spurious)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    assign eng_done = done_m | done_f;

    // Engine model: one-cycle done pulse eng_delay cycles after each start
    always @(negedge clk) begin
        done_m = 1'b0;
        if (done_at >= 0 && cyc == done_at) begin
            done_m  = 1'b1;
            done_at = -1;
        end
        if (eng_start) begin
            starts = starts + 1;
            if (eng_delay >= 0) done_at = cyc + eng_delay;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_resp(input logic is_err, input int idx, input int at);
        exp_t e;
        e.is_err = is_err;
        e.idx    = idx;
        e.at     = at;
        exp_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every ack/err pulse must match the head of the scoreboard
    initial begin
        exp_t         e;
        logic [N-1:0] ea, ee;
        forever begin
            @(negedge clk);
            if ((ack | err) != '0) begin
                if (exp_q.size() == 0) begin
                    n_vec  = n_vec + 1;
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_resp: ack=%b err=%b at cycle %0d, expected none", ack, err, cyc);
                end else begin
                    e  = exp_q.pop_front();
                    ea = '0;
                    ee = '0;
                    if (e.is_err) ee[e.idx] = 1'b1;
                    else          ea[e.idx] = 1'b1;
                    check("resp_vec", 64'({ack, err}), 64'({ea, ee}));
                    check("resp_cycle", 64'(cyc), 64'(e.at));
                end
            end
        end
    end

    initial begin
        int t0, t1, s0;
        rst_n      = 1'b0;
        req        = '0;
        req_secure = '0;
        tick(2);
        check("reset_outputs", 64'({gnt, ack, err, eng_start, eng_secure, busy, spurious}), 64'(0));
        rst_n = 1'b1;
        tick(1);

        // Single secure op, done 2 cycles after start
        t0 = cyc; s0 = starts;
        req = 4'b0001; req_secure = 4'b0001; eng_delay = 2;
        expect_resp(1'b0, 0, t0 + 4);
        tick(1);
        check("t1_gnt_c1", 64'(gnt), 64'(4'b0001));
        check("t1_start_c1", 64'({eng_start, eng_secure, busy}), 64'(3'b111));
        tick(1);
        check("t1_start_c2", 64'({eng_start, eng_secure}), 64'(0));
        check("t1_gnt_c2", 64'(gnt), 64'(4'b0001));
        tick(2);
        check("t1_gnt_c4", 64'(gnt), 64'(4'b0001));
        req = '0;
        tick(1);
        check("t1_idle", 64'({gnt, busy}), 64'(0));
        check("t1_starts", 64'(starts - s0), 64'(1));

        // All four held: grants 0,1,2,3,0 from a fresh pointer
        rst_n = 1'b0; tick(2); rst_n = 1'b1;
        t0 = cyc;
        req = 4'b1111; req_secure = 4'b1111; eng_delay = 2;
        for (int k = 0; k < 5; k++) expect_resp(1'b0, k % 4, t0 + 4 + 5 * k);
        tick(21);
        check("t2_gnt_wrap", 64'(gnt), 64'(4'b0001));
        tick(3);
        req = '0;
        tick(1);

        // Non-secure reject advances pointer to 2
        t0 = cyc; s0 = starts;
        req = 4'b0010; req_secure = 4'b0000;
        expect_resp(1'b1, 1, t0 + 1);
        tick(1);
        check("t3_gnt", 64'(gnt), 64'(4'b0010));
        check("t3_no_start", 64'(eng_start), 64'(0));
        req = '0;
        tick(1);
        req = 4'b0111; req_secure = 4'b1111;
        expect_resp(1'b0, 2, t0 + 6);
        tick(4);
        req = 4'b0011;
        expect_resp(1'b0, 0, t0 + 11);
        tick(5);
        req = '0;
        check("t3_starts", 64'(starts - s0), 64'(2));
        tick(1);

        // Timeout after 16 WAIT cycles, engine started once
        t0 = cyc; s0 = starts;
        req = 4'b0001; req_secure = 4'b0001; eng_delay = -1;
        expect_resp(1'b1, 0, t0 + 18);
        tick(18);
        req = '0;
        check("t4_starts", 64'(starts - s0), 64'(1));
        tick(1);

        // Done on the last WAIT cycle resolves as ok
        t0 = cyc;
        req = 4'b0001; req_secure = 4'b0001; eng_delay = 16;
        expect_resp(1'b0, 0, t0 + 18);
        tick(18);
        req = '0;
        tick(1);

        // Owner drops req after arbitration; response still pulses
        t0 = cyc;
        req = 4'b0100; req_secure = 4'b0100; eng_delay = 2;
        expect_resp(1'b0, 2, t0 + 4);
        tick(1);
        req = '0;
        tick(4);
        check("t5_idle", 64'({gnt, busy}), 64'(0));

        // Spurious done while idle is sticky
        check("t6_spur_pre", 64'(spurious), 64'(0));
        done_f = 1'b1;
        tick(1);
        done_f = 1'b0;
        check("t6_spur_set", 64'(spurious), 64'(1));
        tick(3);
        check("t6_spur_hold", 64'(spurious), 64'(1));

        // Reset during WAIT discards the op; pointer restarts at 0
        t0 = cyc;
        req = 4'b1000; req_secure = 4'b1000; eng_delay = -1;
        tick(3);
        check("t7_wait_busy", 64'({gnt, busy}), 64'({4'b1000, 1'b1}));
        rst_n = 1'b0;
        #1;
        check("t7_rst_async", 64'({gnt, busy, spurious}), 64'(0));
        tick(2);
        rst_n = 1'b1;
        t1 = cyc;
        req = 4'b1001; req_secure = 4'b1001; eng_delay = 2;
        expect_resp(1'b0, 0, t1 + 4);
        tick(4);
        req = 4'b1000;
        expect_resp(1'b0, 3, t1 + 9);
        tick(5);
        req = '0;
        tick(3);

        check("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
